// File: rtl/bs_gnrtr_n_rbtr_pkg.sv
// ============================================================================
// Module : bs_pkg
// Brief  : Shared types and helpers for the bus generator / arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bs_pkg;

    localparam int               ID_W      = 8;
    localparam logic [ID_W-1:0]  BROADCAST = 8'hFF;
    localparam int               MAX_PKT   = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        PUSH = 2'd2
    } state_t;

    // Destination ID lives in the top ID_W bits of an sz-bit packet.
    function automatic logic [ID_W-1:0] id_of(input logic [MAX_PKT-1:0] pkt, input int sz);
        return ID_W'(pkt >> (sz - ID_W));
    endfunction

endpackage

`default_nettype wire

// File: rtl/bs_gnrtr_n_rbtr_rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin pick, scanning upward from last+1.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N  = 16,
    parameter int LW = 4
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    output logic [LW-1:0] grant,
    output logic          any_req
);

    int w_idx;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        grant = '0;
        w_idx = 0;
        for (int k = N; k >= 1; k--) begin
            w_idx = (int'(last) + k) % N;
            if (req[w_idx]) begin
                grant = LW'(w_idx);
            end
        end
    end

    assign any_req = |req;

endmodule

`default_nettype wire

// File: rtl/bs_gnrtr_n_rbtr.sv
// ============================================================================
// Module : bs_gnrtr_n_rbtr
// Brief  : Round-robin shared-bus arbiter moving one packet per 3 cycles.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bs_gnrtr_n_rbtr
    import bs_pkg::*;
#(
    parameter int              pckg_sz   = 24,
    parameter int              drvrs     = 16,
    parameter logic [ID_W-1:0] broadcast = BROADCAST
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [drvrs-1:0]                pndng,
    input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
    output logic [drvrs-1:0]                pop,
    output logic [drvrs-1:0]                push,
    output logic [drvrs-1:0][pckg_sz-1:0]   D_push
);

    localparam int               LW  = (drvrs > 1) ? $clog2(drvrs) : 1;
    localparam logic [drvrs-1:0] ONE = drvrs'(1);

    state_t               r_state, w_state_nxt;
    logic [LW-1:0]        r_last,  w_last_nxt;
    logic [LW-1:0]        r_win,   w_win_nxt;
    logic [pckg_sz-1:0]   r_pkt,   w_pkt_nxt;
    logic [pckg_sz-1:0]   r_dout,  w_dout_nxt;
    logic [drvrs-1:0]     w_pop_nxt, w_push_nxt, w_mask;
    logic [LW-1:0]        w_grant;
    logic                 w_any;
    logic [ID_W-1:0]      w_id;

    rr_arbiter #(
        .N  (drvrs),
        .LW (LW)
    ) u_arb (
        .req     (pndng),
        .last    (r_last),
        .grant   (w_grant),
        .any_req (w_any)
    );

    // Broadcast is tested first so it wins even if it collides with a device index.
    always_comb begin
        w_id = id_of(MAX_PKT'(r_pkt), pckg_sz);
        if (w_id == broadcast) begin
            w_mask = ~(ONE << r_win);
        end else if ({24'd0, w_id} < 32'(drvrs)) begin
            w_mask = ONE << w_id;
        end else begin
            w_mask = '0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_win_nxt   = r_win;
        w_pkt_nxt   = r_pkt;
        w_dout_nxt  = r_dout;
        w_pop_nxt   = '0;
        w_push_nxt  = '0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_win_nxt   = w_grant;
                    w_pkt_nxt   = D_pop[w_grant];
                    w_pop_nxt   = ONE << w_grant;
                    w_state_nxt = POP;
                end
            end
            POP: begin
                w_dout_nxt  = r_pkt;
                w_push_nxt  = w_mask;
                w_state_nxt = PUSH;
            end
            PUSH: begin
                w_last_nxt  = r_win;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_last  <= LW'(drvrs - 1);
            r_win   <= '0;
            r_pkt   <= '0;
            r_dout  <= '0;
            pop     <= '0;
            push    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_win   <= w_win_nxt;
            r_pkt   <= w_pkt_nxt;
            r_dout  <= w_dout_nxt;
            pop     <= w_pop_nxt;
            push    <= w_push_nxt;
        end
    end

    assign D_push = {drvrs{r_dout}};

endmodule

`default_nettype wire

// File: tb/tb_bs_gnrtr_n_rbtr.sv
// ============================================================================
// Module : tb_bs_gnrtr_n_rbtr
// Brief  : Directed plus randomized bench for bs_gnrtr_n_rbtr.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bs_gnrtr_n_rbtr;

    localparam int DRV = 16;
    localparam int PSZ = 24;
    localparam int CW  = DRV * PSZ;

    typedef logic [DRV-1:0][PSZ-1:0] bus_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [DRV-1:0]    pndng;
    bus_t              D_pop;
    logic [DRV-1:0]    pop;
    logic [DRV-1:0]    push;
    bus_t              D_push;

    int total  = 0;
    int passed = 0;

    // reference state: who was served last and what the bus is showing
    int             m_last;
    logic [PSZ-1:0] m_bus;

    bs_gnrtr_n_rbtr #(
        .pckg_sz   (PSZ),
        .drvrs     (DRV),
        .broadcast (8'hFF)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .pndng  (pndng),
        .D_pop  (D_pop),
        .pop    (pop),
        .push   (push),
        .D_push (D_push)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [PSZ-1:0] rnd_pkt();
        logic [7:0]     id;
        logic [PSZ-1:0] p;
        case ($urandom_range(0, 3))
            0:       id = 8'hFF;
            1:       id = 8'($urandom_range(DRV, 254));
            default: id = 8'($urandom_range(0, DRV - 1));
        endcase
        p = PSZ'($urandom);
        p[PSZ-1 -: 8] = id;
        return p;
    endfunction

    function automatic bus_t rnd_bus();
        bus_t b;
        for (int i = 0; i < DRV; i++) b[i] = rnd_pkt();
        return b;
    endfunction

    function automatic int model_winner(input logic [DRV-1:0] req, input int last);
        for (int off = 1; off <= DRV; off++) begin
            if (req[(last + off) % DRV]) return (last + off) % DRV;
        end
        return -1;
    endfunction

    function automatic logic [DRV-1:0] model_dest(input logic [PSZ-1:0] pkt, input int src);
        int id;
        logic [DRV-1:0] m;
        id = int'(pkt[PSZ-1 -: 8]);
        m  = '0;
        if (id == 255) begin
            for (int i = 0; i < DRV; i++) m[i] = (i != src);
        end else if (id < DRV) begin
            m[id] = 1'b1;
        end
        return m;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge where it is idle again.
    task automatic xfer(input logic [DRV-1:0] pnd, input bus_t data, input bit hold, input string tag);
        int             w;
        logic [PSZ-1:0] pkt;
        logic [DRV-1:0] one_hot;
        pndng = pnd;
        D_pop = data;
        w = model_winner(pnd, m_last);
        if (w < 0) begin
            @(negedge clk);
            chk({tag, ".idle_pop"},  pop,    '0);
            chk({tag, ".idle_push"}, push,   '0);
            chk({tag, ".idle_bus"},  D_push, {DRV{m_bus}});
            return;
        end
        pkt     = data[w];
        one_hot = '0;
        one_hot[w] = 1'b1;
        @(negedge clk);
        chk({tag, ".pop"},  pop,  one_hot);
        chk({tag, ".push0"}, push, '0);
        if (!hold) begin
            pndng = DRV'($urandom);
            D_pop = rnd_bus();
        end
        @(negedge clk);
        chk({tag, ".pop_end"}, pop,    '0);
        chk({tag, ".push"},    push,   model_dest(pkt, w));
        chk({tag, ".data"},    D_push, {DRV{pkt}});
        if (!hold) begin
            pndng = DRV'($urandom);
            D_pop = rnd_bus();
        end
        @(negedge clk);
        chk({tag, ".push_end"}, push, '0);
        chk({tag, ".pop_gap"},  pop,  '0);
        m_last = w;
        m_bus  = pkt;
    endtask

    initial begin
        bus_t           b;
        logic [DRV-1:0] p;

        // reset held with everything pending
        reset = 1'b1;
        pndng = '1;
        D_pop = rnd_bus();
        m_last = DRV - 1;
        m_bus  = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_pop",  pop,    '0);
            chk("rst_push", push,   '0);
            chk("rst_bus",  D_push, '0);
        end
        reset = 1'b0;

        b = rnd_bus(); b[3] = 24'h05ABCD;
        xfer(16'h0008, b, 1'b0, "unicast");
        chk("unicast_mask", push, '0);

        b = rnd_bus(); b[7] = 24'hFF1234;
        xfer(16'h0080, b, 1'b0, "bcast");

        b = rnd_bus(); b[2] = 24'h200001;
        xfer(16'h0004, b, 1'b0, "bad_id");
        xfer(16'h0000, rnd_bus(), 1'b0, "hold_bus");

        // fresh reset, then a fixed request pattern held steady
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_last = DRV - 1;
        m_bus  = '0;
        b = rnd_bus();
        for (int r = 0; r < 5; r++) xfer(16'h8101, b, 1'b1, "rr");

        // abort in the pop cycle
        pndng = 16'h0020;
        D_pop = rnd_bus();
        @(negedge clk);
        chk("abort_pop", pop, 16'h0020);
        reset = 1'b1;
        pndng = '0;
        #1;
        chk("abort_pop_clr",  pop,    '0);
        chk("abort_push_clr", push,   '0);
        chk("abort_bus_clr",  D_push, '0);
        @(negedge clk);
        chk("abort_push_rst", push, '0);
        reset = 1'b0;
        m_last = DRV - 1;
        m_bus  = '0;
        @(negedge clk);
        chk("abort_push_after", push, '0);
        xfer(16'h0021, rnd_bus(), 1'b0, "post_abort");

        for (int t = 0; t < 40; t++) begin
            p = DRV'($urandom);
            if ($urandom_range(0, 7) == 0) p = '0;
            xfer(p, rnd_bus(), ($urandom_range(0, 1) == 1), "rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bs_gnrtr_n_rbtr.md
Name: bs_gnrtr_n_rbtr

Overview:
- Shared-bus generator and arbiter connecting `drvrs` device FIFOs.
- Each device exposes a pending flag and the head word of its output FIFO.
- The block grants one device at a time (round-robin), pops its head packet, and pushes it to the destination device(s) named by the packet's 8-bit ID header.
- It is the bus core exercised through bus_if by the environment's per-device drivers and monitors.

Parameters:
- pckg_sz, 24: packet width in bits. Bits [pckg_sz-1:pckg_sz-8] are the destination ID; the rest is payload. Must be ≥ 9.
- drvrs, 16: number of attached devices. Range 2..255.
- broadcast, 8'hFF: ID value that means "deliver to every device except the sender".

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- pndng  input  [drvrs-1:0]  device i's output FIFO is non-empty.
- D_pop  input  [drvrs-1:0][pckg_sz-1:0]  head word of device i's output FIFO, valid while pndng[i] is high.
- pop  output  [drvrs-1:0]  one-cycle pulse that dequeues device i's head word.
- push  output  [drvrs-1:0]  one-cycle pulse that writes D_push[i] into device i's input FIFO.
- D_push  output  [drvrs-1:0][pckg_sz-1:0]  packet delivered on the bus; all lanes carry the same value.

Behaviour:
- Reset (asynchronous, active-high): pop=0, push=0, D_push=0, FSM to IDLE, round-robin pointer last=drvrs-1, so device 0 has first priority. Reset asserted mid-transfer aborts the transfer; no push is issued.
- All outputs are registered. FSM states: IDLE → POP → PUSH → IDLE.
- IDLE:
  - If pndng==0, stay in IDLE.
  - Otherwise pick winner w = the first i with pndng[i]=1, scanning last+1, last+2, … modulo drvrs.
  - Latch pkt_q<=D_pop[w], pop[w]<=1, go to POP.
- POP:
  - pop<=0.
  - id = pkt_q[pckg_sz-1 -: 8].
  - Push mask:
    - id==broadcast → all ones except bit w.
    - id<drvrs → one-hot(id). A packet addressed to the sender itself is delivered to the sender.
    - Otherwise → 0. The packet is dropped silently.
  - D_push[all]<=pkt_q, push<=mask, go to PUSH.
- PUSH: push<=0, last<=w, go to IDLE.
- Timing:
  - pndng sampled at edge N → pop high in cycle N+1 (exactly one cycle).
  - push high in cycle N+2 (exactly one cycle).
  - Next grant sampled at edge N+3, so peak throughput is 1 packet per 3 cycles.
- The packet is forwarded unmodified, including its header.
- D_push holds its value until the next transfer.
- pndng changes while in POP or PUSH are ignored until the next IDLE cycle.
- Fairness: a continuously pending device waits at most drvrs-1 transfers.

Decomposition:
- Package bs_pkg holds:
  - state enum {IDLE, POP, PUSH}
  - ID_W=8
  - default BROADCAST=8'hFF
  - function id_of(pkt) returning the top 8 bits
- One sub-module, rr_arbiter:
  - inputs: req[drvrs], last pointer
  - outputs: grant index, any_req (combinational)

Test Plan:
- Reset check: hold reset high for 3 cycles with pndng=16'hFFFF → pop=push=0 and D_push=0 throughout.
- Unicast, drvrs=16, pckg_sz=24: pndng[3]=1, D_pop[3]=24'h05_ABCD → pop[3] pulses 1 cycle; next cycle push=16'h0020 and D_push=24'h05ABCD.
- Broadcast: device 7 sends 24'hFF_1234 → push=16'hFF7F (all bits except bit 7), data unchanged.
- Invalid ID: device 2 sends 24'h20_0001 → pop[2] pulses, push stays 0, FSM returns to IDLE.
- Round-robin: pndng held at 16'h8101 after reset → grant order 0, 8, 15, 0, … Verify pop pulses are 3 cycles apart.
- Mid-transfer reset: assert reset in the cycle pop is high → push never asserts; after release, device 0 has priority again.
